serial_adder: RTL and testbench

Parametrised, multi-cycle successor to the combinational half adder. It adds or subtracts two WIDTH-bit operands serially, LSB-first, processing DIGIT bits per clock and keeping the carry in a flip-flop between steps. It is used where area matters more than latency. A start/busy/done handshake lets a controller or testbench sequence back-to-back operations.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the serial adder.
// The master drives requests; the slave (the adder) returns status and results.
interface serial_adder_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Serial LSB-first adder/subtractor handling DIGIT bits per clock.
// A carry flip-flop links slices; results appear with a one-cycle done pulse.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = ($clog2(STEPS + 1) < 1) ? 1 : $clog2(STEPS + 1);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 1 and DIGIT must divide WIDTH");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [DIGIT:0]   add_s;
   logic [DIGIT-1:0] slice_s;
   logic             co_s;
   logic [WIDTH-1:0] acc_next_s;
   logic             ovf_next_s;

   // Slice adder and accumulator update for the current step
   always_comb begin
      add_s      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
      slice_s    = add_s[DIGIT-1:0];
      co_s       = add_s[DIGIT];
      acc_next_s = (acc_r >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
      // carry into the MSB is recovered from the MSB's own operands and sum bit
      ovf_next_s = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_s[DIGIT-1] ^ co_s;
   end

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.sub ? ~bus.b : bus.b;
                  carry_r <= bus.sub ? 1'b1 : bus.cin;
                  cnt_r   <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               a_r     <= a_r >> DIGIT;
               b_r     <= b_r >> DIGIT;
               acc_r   <= acc_next_s;
               carry_r <= co_s;
               cnt_r   <= cnt_r + 1'b1;
               if (cnt_r == CW'(STEPS - 1)) begin
                  sum_r   <= acc_next_s;
                  cout_r  <= co_s;
                  ovf_r   <= ovf_next_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sum      = sum_r;
   assign bus.cout     = cout_r;
   assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder in three configurations: 1/1, 8/1 and 8/4.
// Stimulus pushes hand-computed results; a negedge monitor pops them on done.
module tb_serial_adder;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_if #(.WIDTH(1)) bus1  ();
   serial_adder_if #(.WIDTH(8)) bus8  ();
   serial_adder_if #(.WIDTH(8)) bus84 ();

   serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk(clk), .rst_n(rst_n), .bus(bus84));

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
      int         due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic busy_of(input int u);
      case (u)
         0:       return bus1.busy;
         1:       return bus8.busy;
         default: return bus84.busy;
      endcase
   endfunction

   task automatic drive(input int u, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input logic st);
      case (u)
         0: begin
            bus1.a = av[0]; bus1.b = bv[0]; bus1.cin = ci; bus1.sub = sb; bus1.start = st;
         end
         1: begin
            bus8.a = av; bus8.b = bv; bus8.cin = ci; bus8.sub = sb; bus8.start = st;
         end
         default: begin
            bus84.a = av; bus84.b = bv; bus84.cin = ci; bus84.sub = sb; bus84.start = st;
         end
      endcase
   endtask

   // Wait for idle (scribbling inputs while busy), issue one op, push its expectation.
   task automatic op(input int u, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic sb, input logic [7:0] es,
                     input logic ec, input logic eo, input bit hold);
      int   n = 0;
      int   steps;
      exp_t e;
      steps = (u == 1) ? 8 : ((u == 2) ? 2 : 1);
      while (busy_of(u) !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
         drive(u, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               hold ? 1'b1 : 1'($urandom));
      end
      if (busy_of(u) !== 1'b0) begin
         n_cmp++; n_mis++;
         $display("FAIL op_wait u%0d: busy still %b, expected 0", u, busy_of(u));
      end
      drive(u, av, bv, ci, sb, 1'b1);
      e = '{es, ec, eo, cyc + 1 + steps};
      case (u)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
      @(negedge clk);
      if (!hold) drive(u, av, bv, ci, sb, 1'b0);
   endtask

   task automatic mon(input int u, input logic [7:0] s, input logic c, input logic o);
      exp_t e;
      bit   got = 1'b0;
      case (u)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
         n_cmp++; n_mis++;
         $display("FAIL unexpected_done u%0d: done=1, expected 0", u);
      end else begin
         check($sformatf("sum u%0d", u), {24'd0, s}, {24'd0, e.s});
         check($sformatf("cout u%0d", u), {31'd0, c}, {31'd0, e.c});
         check($sformatf("overflow u%0d", u), {31'd0, o}, {31'd0, e.o});
         check($sformatf("latency u%0d", u), cyc, e.due);
      end
   endtask

   always @(negedge clk) begin
      if (bus1.done === 1'b1)  mon(0, {7'd0, bus1.sum}, bus1.cout, bus1.overflow);
      if (bus8.done === 1'b1)  mon(1, bus8.sum, bus8.cout, bus8.overflow);
      if (bus84.done === 1'b1) mon(2, bus84.sum, bus84.cout, bus84.overflow);
   end

   task automatic rst_chk(input string nm, input logic bs, input logic dn,
                          input logic [7:0] s, input logic c, input logic o);
      check({nm, " busy"}, {31'd0, bs}, 32'd0);
      check({nm, " done"}, {31'd0, dn}, 32'd0);
      check({nm, " sum"}, {24'd0, s}, 32'd0);
      check({nm, " cout"}, {31'd0, c}, 32'd0);
      check({nm, " overflow"}, {31'd0, o}, 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() + q1.size() + q2.size()) > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if ((q0.size() + q1.size() + q2.size()) > 0) begin
         n_cmp++; n_mis++;
         $display("FAIL drain: %0d results outstanding, expected 0",
                  q0.size() + q1.size() + q2.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int u = 0; u < 3; u++) drive(u, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_chk("reset u0", bus1.busy, bus1.done, {7'd0, bus1.sum}, bus1.cout, bus1.overflow);
      rst_chk("reset u1", bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow);
      rst_chk("reset u2", bus84.busy, bus84.done, bus84.sum, bus84.cout, bus84.overflow);
      rst_n = 1'b1;
      @(negedge clk);

      // half-adder truth table (overflow equals cout at WIDTH=1 with cin=0)
      op(0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      op(0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
      op(0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
      op(0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      drain();

      op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      op(1, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      op(1, 8'h50, 8'h50, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      op(1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
      drain();

      // abort an add four steps in; nothing is queued, so any done is flagged
      drive(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_chk("midop_reset u1", bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      op(1, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
      drain();

      // start held high: each done cycle accepts the next operation
      op(1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
      op(1, 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      op(1, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
      drive(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      drain();

      op(2, 8'h3C, 8'hC4, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
      op(2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      op(2, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
      op(2, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b1);
      drive(2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
